// File: rtl/bist_pkg.sv
// Shared BIST definitions: mode encoding, per-edge control actions and
// known maximal-length feedback masks for the PRPG/MISR registers.
package bist_pkg;

  typedef enum logic {
    MODE_PRPG = 1'b0,
    MODE_MISR = 1'b1
  } bist_mode_e;

  // What the register does on a given edge once clr has been ruled out.
  typedef enum logic [1:0] {
    StepHold = 2'd0,
    StepLoad = 2'd1,
    StepPrpg = 2'd2,
    StepMisr = 2'd3
  } step_e;

  localparam logic [2:0]  TAPS_3  = 3'b110;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next state of a shift-left Fibonacci LFSR; in MISR mode the
// response word is folded into the shifted value.
module lfsr_next
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_8
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] shifted_o,
  output logic [WIDTH-1:0] next_o
);

  logic fb;

  always_comb begin
    fb        = ^(state_i & TAPS);
    shifted_o = {state_i[WIDTH-2:0], fb};
    next_o    = (mode_i == MODE_MISR) ? (shifted_o ^ data_i) : shifted_o;
  end

endmodule

// File: rtl/prpg_lfsr_param.sv
// Parametrised PRPG/MISR register with runtime seed load, period tracking
// and all-zero lockup recovery.
module prpg_lfsr_param
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH:1]   p_output,
  output logic [WIDTH-1:0] step_cnt,
  output logic             period_done,
  output logic             zero_lock
);

  localparam logic [WIDTH-1:0] CntOne = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pd_q, pd_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] cnt_inc;
  logic             state_zero;
  step_e            action;

  lfsr_next #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_lfsr_next (
    .state_i  (state_q),
    .mode_i   (mode),
    .data_i   (data_in),
    .shifted_o(shifted),
    .next_o   (next_state)
  );

  always_comb begin
    action = StepHold;
    if (load) begin
      action = StepLoad;
    end else if (en) begin
      action = (mode == MODE_MISR) ? StepMisr : StepPrpg;
    end
  end

  always_comb begin
    state_zero = (state_q == '0);
    // Saturate rather than wrap so an overlong run never fakes a short period.
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ref_seed_d = ref_seed_q;
    cnt_d      = cnt_q;
    pd_d       = 1'b0;
    wrap_d     = wrap_q;
    unique case (action)
      StepHold: begin
      end
      StepLoad: begin
        state_d    = seed_in;
        ref_seed_d = seed_in;
        cnt_d      = '0;
        wrap_d     = 1'b0;
      end
      StepMisr: begin
        state_d = next_state;
      end
      StepPrpg: begin
        if (state_zero) begin
          state_d = SEED;
          cnt_d   = CntOne;
          wrap_d  = 1'b0;
        end else begin
          state_d = next_state;
          // wrap_q survives hold/MISR cycles so the count restarts on the
          // first PRPG step after a completed period, not the first edge.
          cnt_d   = wrap_q ? CntOne : cnt_inc;
          pd_d    = (shifted == ref_seed_q);
          wrap_d  = (shifted == ref_seed_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= SEED;
      ref_seed_q <= SEED;
      cnt_q      <= '0;
      pd_q       <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_seed_q <= ref_seed_d;
      cnt_q      <= cnt_d;
      pd_q       <= pd_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    p_output    = state_q;
    step_cnt    = cnt_q;
    period_done = pd_q;
    zero_lock   = state_zero & (mode == MODE_PRPG);
  end

endmodule

// File: tb/tb_prpg_lfsr_param.sv
// Scoreboard bench: a driver pushes the expected post-edge outputs for every
// cycle it drives, a monitor pops and compares one entry after each edge.
module tb_prpg_lfsr_param;

  typedef struct {
    string      nm;
    bit         sel8;
    bit         track;
    logic [7:0] p;
    logic [7:0] c;
    logic       pd;
    logic       zl;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0, en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [2:0] seed3 = '0, data3 = '0;
  logic [7:0] seed8 = '0, data8 = '0;

  logic [3:1] p3;
  logic [2:0] c3;
  logic       pd3, zl3;
  logic [8:1] p8;
  logic [7:0] c8;
  logic       pd8, zl8;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         seen[256];
  int         distinct = 0;
  int         dups = 0;
  logic [2:0] ring3[7];

  always #5 clk = ~clk;

  prpg_lfsr_param #(
    .WIDTH(3),
    .TAPS (3'b110),
    .SEED (3'b001)
  ) dut3 (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .seed_in    (seed3),
    .data_in    (data3),
    .p_output   (p3),
    .step_cnt   (c3),
    .period_done(pd3),
    .zero_lock  (zl3)
  );

  prpg_lfsr_param #(
    .WIDTH(8),
    .TAPS (8'hB8),
    .SEED (8'h01)
  ) dut8 (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .seed_in    (seed8),
    .data_in    (data8),
    .p_output   (p8),
    .step_cnt   (c8),
    .period_done(pd8),
    .zero_lock  (zl8)
  );

  task automatic d3(input string nm, input logic c, input logic e, input logic m,
                    input logic l, input logic [2:0] sd, input logic [2:0] dt,
                    input logic [2:0] ep, input logic [2:0] ec, input logic epd,
                    input logic ezl);
    exp_t x;
    @(negedge clk);
    clr = c; en = e; mode = m; load = l; seed3 = sd; data3 = dt;
    x.nm = nm; x.sel8 = 1'b0; x.track = 1'b0;
    x.p = {5'b0, ep}; x.c = {5'b0, ec}; x.pd = epd; x.zl = ezl;
    sb.push_back(x);
  endtask

  task automatic d8(input string nm, input logic c, input logic e, input logic [7:0] ep,
                    input logic [7:0] ec, input logic epd, input bit trk);
    exp_t x;
    @(negedge clk);
    clr = c; en = e; mode = 1'b0; load = 1'b0; seed8 = '0; data8 = '0;
    x.nm = nm; x.sel8 = 1'b1; x.track = trk;
    x.p = ep; x.c = ec; x.pd = epd; x.zl = 1'b0;
    sb.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t       x;
    logic [7:0] ap, ac;
    logic       apd, azl;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        ap  = x.sel8 ? p8 : {5'b0, p3};
        ac  = x.sel8 ? c8 : {5'b0, c3};
        apd = x.sel8 ? pd8 : pd3;
        azl = x.sel8 ? zl8 : zl3;
        n_chk++;
        if ({ap, ac, apd, azl} !== {x.p, x.c, x.pd, x.zl}) begin
          n_fail++;
          $display("FAIL %s: got p=%h cnt=%0d pd=%b zl=%b, want p=%h cnt=%0d pd=%b zl=%b",
                   x.nm, ap, ac, apd, azl, x.p, x.c, x.pd, x.zl);
        end
        if (x.track) begin
          if (seen[ap]) dups++;
          else distinct++;
          seen[ap] = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    logic [7:0] s;
    ring3 = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

    // Full 3-bit period from reset, then restart of the count.
    d3("t1_clr", 1, 0, 0, 0, 3'b0, 3'b0, 3'b001, 3'd0, 0, 0);
    for (int n = 1; n <= 7; n++) d3("t1_step", 0, 1, 0, 0, 3'b0, 3'b0, ring3[n % 7], 3'(n), n == 7, 0);
    d3("t1_hold_after_pd", 0, 0, 0, 0, 3'b0, 3'b0, 3'b001, 3'd7, 0, 0);
    d3("t1_wrap", 0, 1, 0, 0, 3'b0, 3'b0, 3'b010, 3'd1, 0, 0);

    // Freeze at 011 for five cycles.
    d3("t5_step", 0, 1, 0, 0, 3'b0, 3'b0, 3'b101, 3'd2, 0, 0);
    d3("t5_step", 0, 1, 0, 0, 3'b0, 3'b0, 3'b011, 3'd3, 0, 0);
    for (int n = 0; n < 5; n++) d3("t5_freeze", 0, 0, 0, 0, 3'b0, 3'b0, 3'b011, 3'd3, 0, 0);
    d3("t5_resume", 0, 1, 0, 0, 3'b0, 3'b0, 3'b111, 3'd4, 0, 0);

    // Runtime seed load wins over en; period measured against new seed.
    d3("t2_load", 0, 1, 0, 1, 3'b111, 3'b0, 3'b111, 3'd0, 0, 0);
    for (int n = 1; n <= 7; n++) d3("t2_step", 0, 1, 0, 0, 3'b0, 3'b0, ring3[(4 + n) % 7], 3'(n), n == 7, 0);
    d3("t2_hold", 0, 0, 0, 0, 3'b0, 3'b0, 3'b111, 3'd7, 0, 0);

    // Lockup and recovery.
    d3("t3_load0", 0, 0, 0, 1, 3'b000, 3'b0, 3'b000, 3'd0, 0, 1);
    d3("t3_recover", 0, 1, 0, 0, 3'b0, 3'b0, 3'b001, 3'd1, 0, 0);
    d3("t3_step", 0, 1, 0, 0, 3'b0, 3'b0, 3'b010, 3'd2, 0, 0);

    // MISR compaction, then switch back to PRPG with state preserved.
    d3("t4_load0_misr", 0, 0, 1, 1, 3'b000, 3'b0, 3'b000, 3'd0, 0, 0);
    d3("t4_misr_a", 0, 1, 1, 0, 3'b0, 3'b101, 3'b101, 3'd0, 0, 0);
    d3("t4_misr_b", 0, 1, 1, 0, 3'b0, 3'b001, 3'b010, 3'd0, 0, 0);
    d3("t4_back_prpg", 0, 1, 0, 0, 3'b0, 3'b111, 3'b101, 3'd1, 0, 0);

    // clr beats load, and clr drops a period_done that was about to fire.
    d3("t5_clr_load", 1, 1, 0, 1, 3'b110, 3'b0, 3'b001, 3'd0, 0, 0);
    for (int n = 1; n <= 6; n++) d3("t5b_step", 0, 1, 0, 0, 3'b0, 3'b0, ring3[n], 3'(n), 0, 0);
    d3("t5b_clr_pending", 1, 1, 0, 0, 3'b0, 3'b0, 3'b001, 3'd0, 0, 0);
    d3("t5b_after_clr", 0, 1, 0, 0, 3'b0, 3'b0, 3'b010, 3'd1, 0, 0);

    // Full 8-bit period.
    s = 8'h01;
    d8("t6_clr", 1, 0, 8'h01, 8'd0, 0, 0);
    for (int i = 1; i <= 255; i++) begin
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      d8("t6_step", 0, 1, s, 8'(i), i == 255, 1);
    end
    s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    d8("t6_wrap", 0, 1, s, 8'd1, 0, 0);

    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #3;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    n_chk++;
    if (distinct != 255 || dups != 0 || seen[0]) begin
      n_fail++;
      $display("FAIL t6_unique: distinct=%0d dups=%0d zero_seen=%b, want 255 0 0",
               distinct, dups, seen[0]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
